// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch
// and the MEM-stage data port. Data requests win over fetches, one access is
// in flight at a time, and each access ends with a registered one-cycle
// ready pulse. The pipeline is frozen while either requester is waiting.

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2      // cycles from mem_en to valid mem_rdata, 1..15
) (
    input  logic              clk,
    input  logic              reset,

    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,

    // data (load/store) port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_err,

    // memory macro side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    // pipeline freeze
    output logic              stall_pipe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // The counter starts at MEM_LAT-1 so that WAIT ends in the cycle where
    // mem_rdata becomes valid (MEM_LAT cycles after the grant cycle).
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    owner_t     owner;
    logic       owner_we;      // granted data access was a store
    logic [3:0] cnt;

    logic       grant_dm;
    logic       grant_if;
    logic       dm_misaligned;

    // Grant decode: only in IDLE, data port has priority over fetch.
    always_comb begin
        grant_dm      = (state == IDLE) && dm_req;
        grant_if      = (state == IDLE) && !dm_req && if_req;
        dm_misaligned = (dm_addr[1:0] != 2'b00);
    end

    // Memory strobe and request mux; all memory-side fields stay zero
    // unless a real access is issued this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_dm && !dm_misaligned) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (grant_if) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end
    end

    // A requester is stalled from the moment it raises req until its ready.
    assign stall_pipe = (if_req & ~if_ready) | (dm_req & ~dm_ready);

    // Arbiter FSM: grant in IDLE, time the latency in WAIT, pulse ready in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            owner_we <= 1'b0;
            cnt      <= '0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            dm_err   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every register samples pre-edge values regardless of statement order.
            // Ready and error are single-cycle pulses; they are only set on
            // the transition into RESP.
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            dm_err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        owner    <= OWN_DM;
                        owner_we <= dm_we;
                        if (dm_misaligned) begin
                            // Never reaches the memory; answer with an error.
                            dm_ready <= 1'b1;
                            dm_err   <= 1'b1;
                            state    <= RESP;
                        end else begin
                            cnt      <= CNT_INIT;
                            state    <= WAIT;
                        end
                    end else if (grant_if) begin
                        owner    <= OWN_IF;
                        owner_we <= 1'b0;
                        cnt      <= CNT_INIT;
                        state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            // Stores return no data; keep the last load result.
                            if (!owner_we) begin
                                dm_rdata <= mem_rdata;
                            end
                            dm_ready <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    // Requests are ignored here; the requester drops req at
                    // the edge that ends this cycle.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Two instances are exercised: MEM_LAT=2
// (index 0) and MEM_LAT=1 (index 1), each with its own memory model. The
// expected cycle-by-cycle behaviour of every transaction is computed from
// grant/ready offsets derived from the latency, and expected data comes from
// a shadow copy of memory contents.

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst       [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic [31:0] if_rdata  [2];
    logic        if_ready  [2];
    logic        dm_req    [2];
    logic        dm_we     [2];
    logic [31:0] dm_addr   [2];
    logic [31:0] dm_wdata  [2];
    logic [31:0] dm_rdata  [2];
    logic        dm_ready  [2];
    logic        dm_err    [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        stall_pipe[2];

    logic        mem_load;
    logic [31:0] mem_arr  [2][256];
    logic [31:0] ref_mem  [2][256];
    logic [31:0] rd_pipe  [2][16];

    logic [31:0] exp_if_rdata [2];
    logic [31:0] exp_dm_rdata [2];

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut0 (
        .clk(clk), .reset(rst[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
        .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
        .dm_rdata(dm_rdata[0]), .dm_ready(dm_ready[0]), .dm_err(dm_err[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .stall_pipe(stall_pipe[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
        .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
        .dm_rdata(dm_rdata[1]), .dm_ready(dm_ready[1]), .dm_err(dm_err[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .stall_pipe(stall_pipe[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-latency memory macro model: write on a store strobe, read data
    // travels down a delay line; non-accessed cycles inject junk.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_load) begin
                for (int i = 0; i < 256; i++) mem_arr[g][i] <= ref_mem[g][i];
            end else if (mem_en[g] && mem_we[g]) begin
                mem_arr[g][mem_addr[g][9:2]] <= mem_wdata[g];
            end
            rd_pipe[g][0] <= mem_en[g] ? mem_arr[g][mem_addr[g][9:2]] : $urandom;
            for (int s = 1; s < 16; s++) rd_pipe[g][s] <= rd_pipe[g][s-1];
        end
    end

    assign mem_rdata[0] = rd_pipe[0][1];   // MEM_LAT = 2
    assign mem_rdata[1] = rd_pipe[1][0];   // MEM_LAT = 1

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Quiet cycles with no requests: nothing may happen.
    task automatic idle(input int g, input int n);
        if_req[g] = 1'b0;
        dm_req[g] = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check($sformatf("u%0d.idle.mem_en", g), 32'(mem_en[g]), 32'd0);
            check($sformatf("u%0d.idle.stall", g), 32'(stall_pipe[g]), 32'd0);
            check($sformatf("u%0d.idle.ready", g), {30'd0, if_ready[g], dm_ready[g]}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // One transaction set, starting in an IDLE cycle (offset 0). Expected
    // offsets: DM grant at 0, DM ready at 1 (misaligned) or L+1; IF grant at
    // 0 alone or one cycle after DM ready; IF ready L+1 after its grant.
    task automatic run_trial(input int g, input bit has_if, input logic [31:0] ia,
                             input bit has_dm, input bit we, input logic [31:0] da,
                             input logic [31:0] wd);
        int          lat;
        bit          mis;
        int          dm_rdy;
        int          if_grant;
        int          if_rdy;
        int          last;
        bit          en_exp;
        logic [31:0] a_exp, wd_exp;
        bit          we_exp;
        logic [31:0] new_if, new_dm;
        string       p;

        lat      = lat_of(g);
        mis      = has_dm && (da[1:0] != 2'b00);
        dm_rdy   = has_dm ? (mis ? 1 : lat + 1) : -1;
        if_grant = has_dm ? dm_rdy + 1 : 0;
        if_rdy   = has_if ? if_grant + lat + 1 : -1;
        last     = (if_rdy > dm_rdy) ? if_rdy : dm_rdy;

        new_dm = exp_dm_rdata[g];
        if (has_dm && !mis) begin
            if (we) ref_mem[g][da[9:2]] = wd;
            else    new_dm = ref_mem[g][da[9:2]];
        end
        new_if = has_if ? ref_mem[g][ia[9:2]] : exp_if_rdata[g];

        if_req[g]   = has_if;
        if_addr[g]  = ia;
        dm_req[g]   = has_dm;
        dm_we[g]    = we;
        dm_addr[g]  = da;
        dm_wdata[g] = wd;

        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            p = $sformatf("u%0d.c%0d", g, c);
            en_exp = 1'b0; a_exp = '0; we_exp = 1'b0; wd_exp = '0;
            if (has_dm && !mis && c == 0) begin
                en_exp = 1'b1; a_exp = da; we_exp = we; wd_exp = wd;
            end else if (has_if && c == if_grant) begin
                en_exp = 1'b1; a_exp = ia;
            end
            check({p, ".mem_en"},    32'(mem_en[g]), 32'(en_exp));
            check({p, ".mem_addr"},  mem_addr[g], a_exp);
            check({p, ".mem_we"},    32'(mem_we[g]), 32'(we_exp));
            check({p, ".mem_wdata"}, mem_wdata[g], wd_exp);
            check({p, ".if_ready"},  32'(if_ready[g]), 32'(has_if && c == if_rdy));
            check({p, ".dm_ready"},  32'(dm_ready[g]), 32'(has_dm && c == dm_rdy));
            check({p, ".dm_err"},    32'(dm_err[g]), 32'(mis && c == dm_rdy));
            check({p, ".stall"},     32'(stall_pipe[g]),
                  32'((has_if && c < if_rdy) || (has_dm && c < dm_rdy)));
            check({p, ".if_rdata"},  if_rdata[g], (has_if && c >= if_rdy) ? new_if : exp_if_rdata[g]);
            check({p, ".dm_rdata"},  dm_rdata[g], (has_dm && c >= dm_rdy) ? new_dm : exp_dm_rdata[g]);
            @(posedge clk);
            #1;
            // The requester drops its request at the edge ending RESP and the
            // remaining fields become don't-care.
            if (has_if && c == if_rdy) begin
                if_req[g]  = 1'b0;
                if_addr[g] = $urandom;
            end
            if (has_dm && c == dm_rdy) begin
                dm_req[g]   = 1'b0;
                dm_we[g]    = 1'($urandom_range(0, 1));
                dm_addr[g]  = $urandom;
                dm_wdata[g] = $urandom;
            end
        end
        exp_if_rdata[g] = new_if;
        exp_dm_rdata[g] = new_dm;
    endtask

    // Reset lands while an IF fetch is in WAIT; nothing may be delivered.
    task automatic reset_mid_fetch(input int g, input logic [31:0] ia);
        if_req[g]  = 1'b1;
        if_addr[g] = ia;
        @(negedge clk);
        check($sformatf("u%0d.rst.grant_en", g), 32'(mem_en[g]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check($sformatf("u%0d.rst.wait_stall", g), 32'(stall_pipe[g]), 32'd1);
        check($sformatf("u%0d.rst.wait_ready", g), 32'(if_ready[g]), 32'd0);
        rst[g]    = 1'b1;
        if_req[g] = 1'b0;
        @(posedge clk);
        #1;
        rst[g] = 1'b0;
        exp_if_rdata[g] = '0;
        exp_dm_rdata[g] = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("u%0d.rst.c%0d.if_ready", g, c), 32'(if_ready[g]), 32'd0);
            check($sformatf("u%0d.rst.c%0d.mem_en", g, c), 32'(mem_en[g]), 32'd0);
            check($sformatf("u%0d.rst.c%0d.if_rdata", g, c), if_rdata[g], 32'd0);
            check($sformatf("u%0d.rst.c%0d.dm_rdata", g, c), dm_rdata[g], 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_word_addr();
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    initial begin
        logic [31:0] a;
        int          kind;

        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; if_req[g] = 1'b0; dm_req[g] = 1'b0; dm_we[g] = 1'b0;
            if_addr[g] = '0; dm_addr[g] = '0; dm_wdata[g] = '0;
            for (int i = 0; i < 256; i++) ref_mem[g][i] = $urandom;
            ref_mem[g][32'h40 >> 2] = 32'h2008_0005;
            exp_if_rdata[g] = '0;
            exp_dm_rdata[g] = '0;
        end
        mem_load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_load = 1'b0;

        // Reset values, sampled while reset is still held.
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("u%0d.reset.ready_err", g), {29'd0, if_ready[g], dm_ready[g], dm_err[g]}, 32'd0);
            check($sformatf("u%0d.reset.if_rdata", g), if_rdata[g], 32'd0);
            check($sformatf("u%0d.reset.dm_rdata", g), dm_rdata[g], 32'd0);
            check($sformatf("u%0d.reset.mem_en_we", g), {30'd0, mem_en[g], mem_we[g]}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Directed cases on the MEM_LAT=2 instance.
        idle(0, 2);
        run_trial(0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, '0, '0);
        check("u0.fetch40.value", if_rdata[0], 32'h2008_0005);
        idle(0, 1);
        run_trial(0, 1'b1, rand_word_addr(), 1'b1, 1'b0, 32'h0000_0100, $urandom);
        run_trial(0, 1'b0, '0, 1'b1, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
        run_trial(0, 1'b0, '0, 1'b1, 1'b0, 32'h0000_0102, $urandom);
        run_trial(0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, '0, '0);
        check("u0.store_landed", if_rdata[0], 32'hDEAD_BEEF);
        idle(0, 1);
        reset_mid_fetch(0, rand_word_addr());
        run_trial(0, 1'b1, rand_word_addr(), 1'b0, 1'b0, '0, '0);

        // Directed cases on the MEM_LAT=1 instance: back-to-back loads.
        idle(1, 1);
        run_trial(1, 1'b0, '0, 1'b1, 1'b0, rand_word_addr(), $urandom);
        run_trial(1, 1'b0, '0, 1'b1, 1'b0, rand_word_addr(), $urandom);
        run_trial(1, 1'b1, rand_word_addr(), 1'b1, 1'b1, rand_word_addr(), $urandom);
        reset_mid_fetch(1, rand_word_addr());
        run_trial(1, 1'b1, rand_word_addr(), 1'b0, 1'b0, '0, '0);

        // Randomized traffic on both instances.
        for (int g = 0; g < 2; g++) begin
            for (int t = 0; t < 150; t++) begin
                kind = $urandom_range(0, 3);
                a = rand_word_addr();
                if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
                run_trial(g, kind != 1, rand_word_addr(), kind != 0,
                          1'($urandom_range(0, 1)), a, $urandom);
                if ($urandom_range(0, 3) == 0) idle(g, $urandom_range(1, 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
